// File: rtl/mem_dma.sv
// Byte-serial memory-to-memory copy engine: READ then WRITE per byte, ascending order.
// Optional fill mode (constant pattern, one byte per cycle) is enabled by defining DMA_FILL_EN.
module mem_dma #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
`ifdef DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_val,
`endif
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] buf_q, buf_d;

  logic              fill_req;
  logic              fill_mode;
  logic [DATA_W-1:0] fill_data;

`ifdef DMA_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;

  assign fill_req  = fill;
  assign fill_mode = fill_q;
  assign fill_data = fill_val_q;

  always_comb begin
    fill_d     = fill_q;
    fill_val_d = fill_val_q;
    if (state_q == IDLE && start) begin
      fill_d     = fill;
      fill_val_d = fill_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else begin
      fill_q     <= fill_d;
      fill_val_q <= fill_val_d;
    end
  end
`else
  assign fill_req  = 1'b0;
  assign fill_mode = 1'b0;
  assign fill_data = '0;
`endif

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    cnt_d     = cnt_q;
    buf_d     = buf_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d = src;
          dst_d = dst;
          cnt_d = len;
          if (len == '0)     state_d = DONE;
          else if (fill_req) state_d = WRITE;
          else               state_d = READ;
        end
      end
      READ: begin
        busy     = 1'b1;
        mem_addr = src_q;
        buf_d    = mem_rdata;
        state_d  = WRITE;
      end
      WRITE: begin
        busy      = 1'b1;
        mem_addr  = dst_q;
        mem_wdata = fill_mode ? fill_data : buf_q;
        // Suppress the strobe while reset is held so an abort commits nothing further.
        mem_write = ~rst;
        src_d     = src_q + 1'b1;
        dst_d     = dst_q + 1'b1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == ADDR_W'(1)) state_d = DONE;
        else if (fill_mode)      state_d = WRITE;
        else                     state_d = READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule
